// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared card rank type, rank limits and baccarat card value helper.
package baccarat_pkg;
   localparam logic [3:0] RANK_MIN   = 4'd1;
   localparam logic [3:0] RANK_MAX   = 4'd13;
   localparam logic [3:0] RANK_EMPTY = 4'd0;
   typedef logic [3:0] rank_t;
   function automatic logic [3:0] card_value(input rank_t rank);
      return (rank >= RANK_MIN && rank <= 4'd9) ? rank : 4'd0;
   endfunction
endpackage

// File: rtl/baccarat_hand_datapath_hand_score.sv
// hand_score: combinational mod-10 baccarat score of a three-card hand.
module hand_score
   import baccarat_pkg::*;
(
   input  rank_t      c1_i,
   input  rank_t      c2_i,
   input  rank_t      c3_i,
   output logic [3:0] score_o
);
   logic [4:0] sum, s1;
   assign sum = 5'(card_value(c1_i)) + 5'(card_value(c2_i)) + 5'(card_value(c3_i));
   assign s1 = (sum >= 5'd10) ? sum - 5'd10 : sum;
   assign score_o = (s1 >= 5'd10) ? 4'(s1 - 5'd10) : s1[3:0];
endmodule

// File: rtl/baccarat_hand_datapath.sv
// baccarat_hand_datapath: deal counter, hand slots, strobe arbitration and round tallies.
module baccarat_hand_datapath
   import baccarat_pkg::*;
#(
   parameter int TALLY_W = 8
) (
   input  logic               slow_clock,
   input  logic               resetb,
   input  logic               load_pcard1,
   input  logic               load_pcard2,
   input  logic               load_pcard3,
   input  logic               load_dcard1,
   input  logic               load_dcard2,
   input  logic               load_dcard3,
   input  logic               endround,
   input  logic               player_win_light,
   input  logic               dealer_win_light,
   output logic [3:0]         pcard1,
   output logic [3:0]         pcard2,
   output logic [3:0]         pcard3,
   output logic [3:0]         dcard1,
   output logic [3:0]         dcard2,
   output logic [3:0]         dcard3,
   output logic [3:0]         pscore,
   output logic [3:0]         dscore,
   output logic [3:0]         pcard3_val,
   output logic [TALLY_W-1:0] player_wins,
   output logic [TALLY_W-1:0] dealer_wins,
   output logic [TALLY_W-1:0] ties,
   output logic [TALLY_W-1:0] rounds,
   output logic               protocol_error
);
   function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] x, input logic en);
      return (en && !(&x)) ? x + TALLY_W'(1) : x;
   endfunction
   rank_t deal_q, deal_d;
   rank_t slot_q [6];
   rank_t slot_d [6];
   logic [5:0] ld, sel;
   logic multi, err_q, err_d, end_q, rise;
   logic [TALLY_W-1:0] pw_q, pw_d, dw_q, dw_d, tie_q, tie_d, rnd_q, rnd_d;
   assign ld = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
   // lowest index has priority: isolate the lowest set bit
   assign sel = ld & (~ld + 6'd1);
   assign multi = |(ld & (ld - 6'd1));
   assign rise = endround & ~end_q;
   always_comb begin
      deal_d = (deal_q == RANK_MAX) ? RANK_MIN : deal_q + 4'd1;
      for (int i = 0; i < 6; i++)
         slot_d[i] = sel[i] ? deal_q : (sel[0] ? RANK_EMPTY : slot_q[i]);
      err_d = err_q | multi;
      pw_d  = sat_inc(pw_q, rise & player_win_light & ~dealer_win_light);
      dw_d  = sat_inc(dw_q, rise & dealer_win_light & ~player_win_light);
      tie_d = sat_inc(tie_q, rise & player_win_light & dealer_win_light);
      rnd_d = sat_inc(rnd_q, rise);
   end
   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         deal_q <= RANK_MIN;
         slot_q <= '{default: RANK_EMPTY};
         err_q  <= 1'b0;
         end_q  <= 1'b0;
         pw_q   <= '0;
         dw_q   <= '0;
         tie_q  <= '0;
         rnd_q  <= '0;
      end else begin
         deal_q <= deal_d;
         slot_q <= slot_d;
         err_q  <= err_d;
         end_q  <= endround;
         pw_q   <= pw_d;
         dw_q   <= dw_d;
         tie_q  <= tie_d;
         rnd_q  <= rnd_d;
      end
   end
   hand_score u_player (.c1_i(slot_q[0]), .c2_i(slot_q[1]), .c3_i(slot_q[2]), .score_o(pscore));
   hand_score u_dealer (.c1_i(slot_q[3]), .c2_i(slot_q[4]), .c3_i(slot_q[5]), .score_o(dscore));
   assign pcard1 = slot_q[0];
   assign pcard2 = slot_q[1];
   assign pcard3 = slot_q[2];
   assign dcard1 = slot_q[3];
   assign dcard2 = slot_q[4];
   assign dcard3 = slot_q[5];
   assign pcard3_val = card_value(slot_q[2]);
   assign player_wins = pw_q;
   assign dealer_wins = dw_q;
   assign ties = tie_q;
   assign rounds = rnd_q;
   assign protocol_error = err_q;
endmodule

// File: tb/tb_baccarat_hand_datapath.sv
// tb_baccarat_hand_datapath: directed vectors with hand-computed expectations.
module tb_baccarat_hand_datapath;
   logic slow_clock = 1'b0;
   logic resetb = 1'b0;
   logic [5:0] ld = '0;
   logic endround = 1'b0, player_win_light = 1'b0, dealer_win_light = 1'b0;
   logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore, pcard3_val;
   logic [7:0] player_wins, dealer_wins, ties, rounds;
   logic protocol_error;
   int passed = 0, total = 0, deal = 1;
   localparam int P1 = 0, P2 = 1, P3 = 2, D1 = 3, D2 = 4, D3 = 5;
   baccarat_hand_datapath dut (
      .slow_clock(slow_clock), .resetb(resetb),
      .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
      .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
      .endround(endround), .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
      .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
      .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
      .pscore(pscore), .dscore(dscore), .pcard3_val(pcard3_val),
      .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties), .rounds(rounds),
      .protocol_error(protocol_error)
   );
   always #5 slow_clock = ~slow_clock;
   task automatic check(input string tag, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask
   // deal tracks the counter value the DUT will sample at the next edge
   task automatic tick();
      @(posedge slow_clock);
      #1;
      deal = !resetb ? 1 : (deal == 13 ? 1 : deal + 1);
   endtask
   task automatic load(input int idx, input int rank);
      for (int i = 0; i < 13 && deal != rank; i++) tick();
      ld = 6'b1 << idx;
      tick();
      ld = '0;
   endtask
   task automatic pulse(input logic pl, input logic dl);
      player_win_light = pl;
      dealer_win_light = dl;
      endround = 1'b1;
      tick();
      endround = 1'b0;
      tick();
   endtask
   task automatic check_all_zero(input string tag);
      check({tag, "_p1"}, pcard1, 0);
      check({tag, "_p2"}, pcard2, 0);
      check({tag, "_p3"}, pcard3, 0);
      check({tag, "_d1"}, dcard1, 0);
      check({tag, "_d2"}, dcard2, 0);
      check({tag, "_d3"}, dcard3, 0);
      check({tag, "_ps"}, pscore, 0);
      check({tag, "_ds"}, dscore, 0);
      check({tag, "_p3v"}, pcard3_val, 0);
      check({tag, "_pw"}, player_wins, 0);
      check({tag, "_dw"}, dealer_wins, 0);
      check({tag, "_tie"}, ties, 0);
      check({tag, "_rnd"}, rounds, 0);
      check({tag, "_err"}, protocol_error, 0);
   endtask
   initial begin
      tick();
      tick();
      check_all_zero("rst");
      resetb = 1'b1;
      load(P1, 7);
      load(P2, 13);
      check("ld_p1", pcard1, 7);
      check("ld_p2", pcard2, 13);
      check("ld_ps", pscore, 7);
      check("ld_p3v", pcard3_val, 0);
      load(P1, 9);
      check("clr_p2", pcard2, 0);
      load(P2, 8);
      load(P3, 5);
      check("wrap_ps", pscore, 2);
      check("wrap_p3v", pcard3_val, 5);
      load(P3, 12);
      check("face_p3v", pcard3_val, 0);
      check("face_ps", pscore, 7);
      load(P1, 1);
      load(P2, 2);
      load(P3, 3);
      load(D1, 4);
      load(D2, 5);
      load(D3, 6);
      check("fill_ps", pscore, 6);
      check("fill_ds", dscore, 5);
      check("fill_d3", dcard3, 6);
      load(P1, 10);
      check("new_p1", pcard1, 10);
      check("new_p2", pcard2, 0);
      check("new_p3", pcard3, 0);
      check("new_d1", dcard1, 0);
      check("new_d2", dcard2, 0);
      check("new_d3", dcard3, 0);
      check("new_ds", dscore, 0);
      check("new_ps", pscore, 0);
      load(D1, 4);
      check("pre_err", protocol_error, 0);
      for (int i = 0; i < 13 && deal != 11; i++) tick();
      ld = 6'b001010;
      tick();
      ld = '0;
      check("sim_p2", pcard2, 11);
      check("sim_d1", dcard1, 4);
      check("sim_err", protocol_error, 1);
      for (int i = 0; i < 10; i++) tick();
      check("sticky_err", protocol_error, 1);
      player_win_light = 1'b1;
      dealer_win_light = 1'b1;
      endround = 1'b1;
      tick();
      check("tie_lat", ties, 1);
      tick();
      tick();
      endround = 1'b0;
      tick();
      check("tie_ties", ties, 1);
      check("tie_rnd", rounds, 1);
      check("tie_pw", player_wins, 0);
      pulse(1'b0, 1'b1);
      check("dw_dw", dealer_wins, 1);
      check("dw_rnd", rounds, 2);
      pulse(1'b0, 1'b0);
      check("none_rnd", rounds, 3);
      check("none_pw", player_wins, 0);
      check("none_dw", dealer_wins, 1);
      check("none_tie", ties, 1);
      for (int i = 0; i < 300; i++) pulse(1'b1, 1'b0);
      check("sat_pw", player_wins, 255);
      check("sat_rnd", rounds, 255);
      check("sat_dw", dealer_wins, 1);
      check("sat_tie", ties, 1);
      load(P1, 3);
      load(P2, 6);
      load(D1, 8);
      load(D2, 2);
      check("mid_ps", pscore, 9);
      check("mid_ds", dscore, 0);
      resetb = 1'b0;
      ld = 6'b1 << D1;
      tick();
      ld = '0;
      check_all_zero("mid_rst");
      resetb = 1'b1;
      ld = 6'b1 << P1;
      tick();
      ld = '0;
      check("post_p1", pcard1, 1);
      check("post_ps", pscore, 1);
      check("post_d1", dcard1, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
